count_checker: RTL and testbench
================================

COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4, which sets the bit width of the observed count.
REQ-002 SHALL have parameter LOCK_CNT, default 4, which sets the number of consecutive matching samples required before locked asserts.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all sampling is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port count, input, WIDTH bits: the count value driven by the counter under observation.
REQ-006 SHALL have port enable, input, 1 bit: the same enable that drives the observed counter.
REQ-007 SHALL have port clr_err, input, 1 bit: synchronous clear of the error statistics.
REQ-008 SHALL have port expected, output, WIDTH bits: the predicted count for the next sample.
REQ-009 SHALL have port locked, output, 1 bit: high once tracking is confirmed.
REQ-010 SHALL have port err_pulse, output, 1 bit: one-cycle pulse on each mismatch.
REQ-011 SHALL have port err_sticky, output, 1 bit: set by any mismatch and held until cleared.
REQ-012 SHALL have port err_cnt, output, 8 bits: saturating count of mismatches.
REQ-013 SHALL have port wrap_pulse, output, 1 bit: one-cycle pulse on each legal wrap (see REQ-030).

Function
REQ-014 SHALL implement a registered state machine with three states: IDLE, TRACK and RESYNC.
REQ-015 SHALL, in IDLE, capture ref=count and ref_en=enable on the first edge after reset, set expected=count+enable modulo 2^WIDTH, and go to TRACK.
REQ-016 SHALL, in TRACK on each edge, compare count against expected.
- On a match: set expected=count+enable modulo 2^WIDTH and increment the match counter, saturating at LOCK_CNT.
REQ-017 SHALL, on a mismatch in TRACK:
- pulse err_pulse for exactly one cycle;
- set err_sticky;
- increment err_cnt, saturating at 255;
- clear the match counter and deassert locked;
- go to RESYNC.
REQ-018 SHALL, in RESYNC, recapture as in IDLE with no comparison, then return to TRACK.
REQ-019 SHALL assert locked when state is TRACK and the match counter equals LOCK_CNT; it is registered and rises on the edge of the LOCK_CNT-th consecutive match.
REQ-020 SHALL treat enable=0 as a hold: the next expected value equals the current count.
REQ-021 SHALL perform all arithmetic modulo 2^WIDTH; a step from 2^WIDTH-1 to 0 with enable=1 is a match.
REQ-022 SHALL, when clr_err=1, zero err_cnt and err_sticky at the next edge.
- If a mismatch occurs on that same edge, the mismatch wins over the clear: err_cnt=1 and err_sticky=1.
- clr_err has no effect on the state machine, expected or locked.
REQ-023 SHALL leave err_cnt unchanged at 255 on further mismatches; err_pulse still asserts.
REQ-024 SHALL drive all outputs directly from registers.

Reset
REQ-025 SHALL, while reset=1, asynchronously force state=IDLE, expected=0, match counter=0, and each of locked, err_pulse, err_sticky, err_cnt and wrap_pulse to 0.
REQ-026 SHALL, if reset asserts during TRACK or RESYNC, abandon the current state immediately and restart from IDLE after release, with no error reported.
REQ-027 SHALL make no comparison on the first edge after reset release.

Configuration
REQ-028 SHALL use the macro COUNT_CHK_WRAP_EN to select wrap reporting.
REQ-029 SHALL, without COUNT_CHK_WRAP_EN, hold wrap_pulse at a constant 0 and synthesise no wrap detection logic.
REQ-030 SHALL, with COUNT_CHK_WRAP_EN defined, pulse wrap_pulse for one cycle on a TRACK match where the previous sample was 2^WIDTH-1 with enable=1 and the current sample is 0.

Verification
REQ-031 SHALL cover lock-up: WIDTH=4, reset then enable=1 with count 0,1,2,3,4,5 -> locked=1 on the edge that samples 4, and err_cnt=0.
REQ-032 SHALL cover hold: count 7,7,7 with enable=0, then 8 with enable=1 -> no err_pulse, and expected=9 after the sample of 8.
REQ-033 SHALL cover a single fault: count 3,4,9,10,11 with enable=1 -> err_pulse on the sample of 9, err_cnt=1, err_sticky=1, locked=0, then re-lock with no further errors.
REQ-034 SHALL cover wrap: count 14,15,0,1 with enable=1 -> no error; wrap_pulse=1 for one cycle on the sample of 0 only if COUNT_CHK_WRAP_EN is defined, else 0.
REQ-035 SHALL cover clear/error collision: clr_err=1 on the same edge as a mismatch while err_cnt=5 -> err_cnt=1 and err_sticky=1.
REQ-036 SHALL cover reset mid-TRACK with err_cnt=3: pulse reset -> all outputs 0 immediately, and the first post-reset edge produces no err_pulse.

Source files
------------

// File: rtl/count_checker.sv
// Tracks a free-running counter, predicts its next sample, locks after LOCK_CNT clean matches and counts mismatches.
// Optional wrap reporting is enabled by defining COUNT_CHK_WRAP_EN.
module count_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic             enable,
  input  logic             clr_err,
  output logic [WIDTH-1:0] expected,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [7:0]       err_cnt,
  output logic             wrap_pulse
);

  localparam int MW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {IDLE, TRACK, RESYNC} state_t;

  state_t           state, state_next;
  logic [MW-1:0]    match_cnt, match_next;
  logic [WIDTH-1:0] expected_next, captured;
  logic             locked_next, err_pulse_next, err_sticky_next;
  logic [7:0]       err_cnt_next;
  logic             mismatch;
`ifdef COUNT_CHK_WRAP_EN
  logic             last_max;
  logic             wrap_next;
`endif

  assign captured = count + WIDTH'(enable);
  assign mismatch = (state == TRACK) && (count != expected);

  // State and all output registers; outputs never come from combinational paths
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      expected   <= '0;
      match_cnt  <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= 8'd0;
`ifdef COUNT_CHK_WRAP_EN
      wrap_pulse <= 1'b0;
      last_max   <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      expected   <= expected_next;
      match_cnt  <= match_next;
      locked     <= locked_next;
      err_pulse  <= err_pulse_next;
      err_sticky <= err_sticky_next;
      err_cnt    <= err_cnt_next;
`ifdef COUNT_CHK_WRAP_EN
      wrap_pulse <= wrap_next;
      last_max   <= (count == {WIDTH{1'b1}}) && enable;
`endif
    end
  end

`ifndef COUNT_CHK_WRAP_EN
  assign wrap_pulse = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = TRACK;
      TRACK:   state_next = mismatch ? RESYNC : TRACK;
      RESYNC:  state_next = TRACK;
      default: state_next = IDLE;
    endcase
  end

  // A mismatch on the same edge as clr_err wins, so the new error is never lost
  always_comb begin
    expected_next   = expected;
    match_next      = match_cnt;
    locked_next     = locked;
    err_pulse_next  = 1'b0;
    err_sticky_next = clr_err ? 1'b0 : err_sticky;
    err_cnt_next    = clr_err ? 8'd0 : err_cnt;
`ifdef COUNT_CHK_WRAP_EN
    wrap_next       = 1'b0;
`endif
    case (state)
      TRACK: begin
        if (mismatch) begin
          err_pulse_next  = 1'b1;
          err_sticky_next = 1'b1;
          err_cnt_next    = clr_err ? 8'd1 :
                            ((err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1);
          match_next      = '0;
          locked_next     = 1'b0;
        end else begin
          expected_next = captured;
          match_next    = (match_cnt == MW'(LOCK_CNT)) ? match_cnt : match_cnt + MW'(1);
          locked_next   = (match_next == MW'(LOCK_CNT));
`ifdef COUNT_CHK_WRAP_EN
          wrap_next     = last_max && (count == '0);
`endif
        end
      end
      default: begin
        expected_next = captured;
        match_next    = '0;
        locked_next   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_count_checker.sv
// Table-driven bench for count_checker (WIDTH=4, LOCK_CNT=4), plus hand sequences for reset and saturation.
module tb_count_checker;

  logic       clk;
  logic       reset;
  logic [3:0] count;
  logic       enable;
  logic       clr_err;
  logic [3:0] expected;
  logic       locked;
  logic       err_pulse;
  logic       err_sticky;
  logic [7:0] err_cnt;
  logic       wrap_pulse;

  int total = 0;
  int bad   = 0;

`ifdef COUNT_CHK_WRAP_EN
  localparam int WRAP_ON = 1;
`else
  localparam int WRAP_ON = 0;
`endif

  typedef struct {
    int rst; int cnt; int en; int clr;
    int x_exp; int x_lock; int x_ep; int x_st; int x_ec; int x_wrap;
  } vec_t;

  vec_t vecs[$];

  count_checker #(.WIDTH(4), .LOCK_CNT(4)) dut (
    .clk(clk), .reset(reset), .count(count), .enable(enable), .clr_err(clr_err),
    .expected(expected), .locked(locked), .err_pulse(err_pulse),
    .err_sticky(err_sticky), .err_cnt(err_cnt), .wrap_pulse(wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int idx, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("[TB] FAIL %s step=%0d got=%0d want=%0d", name, idx, act, want);
    end
  endtask

  // Drive on the falling edge, optional reset pulse first, then sample 1ns after the rising edge
  task automatic applyStimulus(input int r, input int c, input int e, input int cl);
    @(negedge clk);
    if (r != 0) begin
      reset = 1'b1;
      #1;
      reset = 1'b0;
    end
    count   = 4'(c);
    enable  = (e != 0);
    clr_err = (cl != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input int idx, input int xe, input int xl, input int xp,
                          input int xs, input int xc, input int xw);
    checkOutput("expected",   idx, int'(expected),   xe);
    checkOutput("locked",     idx, int'(locked),     xl);
    checkOutput("err_pulse",  idx, int'(err_pulse),  xp);
    checkOutput("err_sticky", idx, int'(err_sticky), xs);
    checkOutput("err_cnt",    idx, int'(err_cnt),    xc);
    checkOutput("wrap_pulse", idx, int'(wrap_pulse), xw);
  endtask

  initial begin
    reset   = 1'b1;
    count   = 4'd0;
    enable  = 1'b0;
    clr_err = 1'b0;

    //                 rst cnt en clr  exp lock ep st ec wrap
    // lock-up
    vecs.push_back(vec_t'{1,  0, 1, 0,   1, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{0,  1, 1, 0,   2, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{0,  2, 1, 0,   3, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{0,  3, 1, 0,   4, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{0,  4, 1, 0,   5, 1, 0, 0, 0, 0});
    vecs.push_back(vec_t'{0,  5, 1, 0,   6, 1, 0, 0, 0, 0});
    // hold
    vecs.push_back(vec_t'{0,  6, 1, 0,   7, 1, 0, 0, 0, 0});
    vecs.push_back(vec_t'{0,  7, 0, 0,   7, 1, 0, 0, 0, 0});
    vecs.push_back(vec_t'{0,  7, 0, 0,   7, 1, 0, 0, 0, 0});
    vecs.push_back(vec_t'{0,  7, 0, 0,   7, 1, 0, 0, 0, 0});
    vecs.push_back(vec_t'{0,  7, 1, 0,   8, 1, 0, 0, 0, 0});
    vecs.push_back(vec_t'{0,  8, 1, 0,   9, 1, 0, 0, 0, 0});
    // single fault then re-lock
    vecs.push_back(vec_t'{1,  3, 1, 0,   4, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{0,  4, 1, 0,   5, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{0,  9, 1, 0,   5, 0, 1, 1, 1, 0});
    vecs.push_back(vec_t'{0, 10, 1, 0,  11, 0, 0, 1, 1, 0});
    vecs.push_back(vec_t'{0, 11, 1, 0,  12, 0, 0, 1, 1, 0});
    vecs.push_back(vec_t'{0, 12, 1, 0,  13, 0, 0, 1, 1, 0});
    vecs.push_back(vec_t'{0, 13, 1, 0,  14, 0, 0, 1, 1, 0});
    vecs.push_back(vec_t'{0, 14, 1, 0,  15, 1, 0, 1, 1, 0});
    // wrap
    vecs.push_back(vec_t'{0, 15, 1, 0,   0, 1, 0, 1, 1, 0});
    vecs.push_back(vec_t'{0,  0, 1, 0,   1, 1, 0, 1, 1, 1});
    vecs.push_back(vec_t'{0,  1, 1, 0,   2, 1, 0, 1, 1, 0});
    // build err_cnt to 5, then clear colliding with a mismatch
    vecs.push_back(vec_t'{0,  9, 1, 0,   2, 0, 1, 1, 2, 0});
    vecs.push_back(vec_t'{0, 10, 1, 0,  11, 0, 0, 1, 2, 0});
    vecs.push_back(vec_t'{0,  5, 1, 0,  11, 0, 1, 1, 3, 0});
    vecs.push_back(vec_t'{0,  6, 1, 0,   7, 0, 0, 1, 3, 0});
    vecs.push_back(vec_t'{0,  0, 1, 0,   7, 0, 1, 1, 4, 0});
    vecs.push_back(vec_t'{0,  1, 1, 0,   2, 0, 0, 1, 4, 0});
    vecs.push_back(vec_t'{0,  8, 1, 0,   2, 0, 1, 1, 5, 0});
    vecs.push_back(vec_t'{0,  9, 1, 0,  10, 0, 0, 1, 5, 0});
    vecs.push_back(vec_t'{0,  3, 1, 1,  10, 0, 1, 1, 1, 0});
    vecs.push_back(vec_t'{0,  4, 1, 0,   5, 0, 0, 1, 1, 0});
    vecs.push_back(vec_t'{0,  5, 1, 1,   6, 0, 0, 0, 0, 0});
    // reach err_cnt=3 while in TRACK
    vecs.push_back(vec_t'{0,  0, 1, 0,   6, 0, 1, 1, 1, 0});
    vecs.push_back(vec_t'{0,  1, 1, 0,   2, 0, 0, 1, 1, 0});
    vecs.push_back(vec_t'{0,  9, 1, 0,   2, 0, 1, 1, 2, 0});
    vecs.push_back(vec_t'{0, 10, 1, 0,  11, 0, 0, 1, 2, 0});
    vecs.push_back(vec_t'{0,  0, 1, 0,  11, 0, 1, 1, 3, 0});
    vecs.push_back(vec_t'{0,  1, 1, 0,   2, 0, 0, 1, 3, 0});
    vecs.push_back(vec_t'{0,  2, 1, 0,   3, 0, 0, 1, 3, 0});

    #2;
    checkAll(-1, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].cnt, vecs[i].en, vecs[i].clr);
      checkAll(i, vecs[i].x_exp, vecs[i].x_lock, vecs[i].x_ep, vecs[i].x_st,
               vecs[i].x_ec, vecs[i].x_wrap * WRAP_ON);
    end

    // Reset mid-TRACK with err_cnt=3: outputs clear without waiting for a clock edge
    #2;
    reset = 1'b1;
    #1;
    checkAll(100, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(0, 7, 1, 0);
    checkAll(101, 8, 0, 0, 0, 0, 0);

    // Saturation: 256 mismatch/resync pairs, err_cnt sticks at 255 while err_pulse keeps firing
    for (int k = 0; k < 256; k++) begin
      applyStimulus(0, 0, 1, 0);
      if (k == 255) begin
        checkOutput("sat_err_cnt", 200, int'(err_cnt), 255);
        checkOutput("sat_err_pulse", 200, int'(err_pulse), 1);
      end
      applyStimulus(0, 7, 1, 0);
    end
    applyStimulus(0, 8, 1, 1);
    checkAll(201, 9, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
